// File: rtl/imul_pkg.sv
// imul_pkg: shared state encoding and default widths for the multiplier response accumulator
package imul_pkg;
  localparam int P_NBITS     = 32;
  localparam int P_LEN_NBITS = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/imul_resp_acc_if.sv
// imul_resp_acc_if: command, product and sum val/rdy channels of the accumulator
interface imul_resp_acc_if #(
  parameter int p_nbits     = 32,
  parameter int p_len_nbits = 8
);
  logic                   cmd_val;
  logic                   cmd_rdy;
  logic [p_len_nbits-1:0] cmd_len;
  logic                   in_val;
  logic                   in_rdy;
  logic [p_nbits-1:0]     in_msg;
  logic                   out_val;
  logic                   out_rdy;
  logic [p_nbits-1:0]     out_msg;
  logic                   out_ovf;
  modport master (
    output cmd_val, cmd_len, in_val, in_msg, out_rdy,
    input  cmd_rdy, in_rdy, out_val, out_msg, out_ovf
  );
  modport slave (
    input  cmd_val, cmd_len, in_val, in_msg, out_rdy,
    output cmd_rdy, in_rdy, out_val, out_msg, out_ovf
  );
endinterface

// File: rtl/imul_resp_acc_dpath.sv
// imul_resp_acc_dpath: running sum, sticky carry flag and remaining-product down-counter
module imul_resp_acc_dpath #(
  parameter int p_nbits     = 32,
  parameter int p_len_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   add,
  input  logic [p_len_nbits-1:0] len,
  input  logic [p_nbits-1:0]     msg,
  output logic [p_nbits-1:0]     acc,
  output logic                   ovf,
  output logic                   remaining_is_one,
  output logic                   len_is_zero
);
  logic [p_len_nbits-1:0] remaining;
  logic [p_nbits:0]       sum;
  assign sum              = {1'b0, acc} + {1'b0, msg};
  assign remaining_is_one = remaining == p_len_nbits'(1);
  assign len_is_zero      = len == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (add) begin
      acc       <= sum[p_nbits-1:0];
      ovf       <= ovf | sum[p_nbits];
      remaining <= remaining - 1'b1;
    end
  end
endmodule

// File: rtl/imul_resp_acc.sv
// imul_resp_acc: sums N multiplier responses per command and emits one sum with a sticky carry flag
module imul_resp_acc
  import imul_pkg::*;
#(
  parameter int p_nbits     = P_NBITS,
  parameter int p_len_nbits = P_LEN_NBITS
) (
  input logic             clk,
  input logic             reset,
  imul_resp_acc_if.slave  bus
);
  state_e state;
  logic   cmd_go, in_go, out_go, remaining_is_one, len_is_zero;
  // ready/valid depend on state alone, so no input val reaches an output rdy
  assign bus.cmd_rdy = state == IDLE;
  assign bus.in_rdy  = state == ACC;
  assign bus.out_val = state == DONE;
  assign cmd_go      = bus.cmd_val && bus.cmd_rdy;
  assign in_go       = bus.in_val && bus.in_rdy;
  assign out_go      = bus.out_val && bus.out_rdy;
  imul_resp_acc_dpath #(.p_nbits(p_nbits), .p_len_nbits(p_len_nbits)) dpath (
    .clk              (clk),
    .reset            (reset),
    .load             (cmd_go),
    .add              (in_go),
    .len              (bus.cmd_len),
    .msg              (bus.in_msg),
    .acc              (bus.out_msg),
    .ovf              (bus.out_ovf),
    .remaining_is_one (remaining_is_one),
    .len_is_zero      (len_is_zero)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= cmd_go ? (len_is_zero ? DONE : ACC) :
                  (in_go && remaining_is_one) ? DONE :
                  out_go ? IDLE : state;
  end
endmodule
